stage_seq: RTL

- Parametrised N-stage program sequencer; next generation of the fixed three-stage wash/rinse/dry run controller.
- Executes the stages selected by a bitmask, one at a time, with a per-stage duration in time units and a built-in time-unit divider. No sub-program instance is required.
- Adds skip, a selectable stage order, per-stage durations, and exact remaining-time reporting.
- Sits between the mode/menu front end (mask, durations, pause, clear) and the display/LED drivers (pending mask, current stage, remaining time).

---
 rtl/stage_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/stage_seq.sv
`default_nettype none
// ============================================================================
//  Module   : stage_seq
//  Function : N-stage program sequencer. Runs the stages of a captured
//             bitmask one at a time, each for a per-stage number of time units.
//  Revision : 1.0 - initial release
// ============================================================================
module stage_seq #(
    parameter int N_STG     = 3,
    parameter int TW        = 6,
    parameter int TIM_CMAX  = 1000,
    parameter int LSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_STG-1:0]           init,
    input  logic [N_STG*TW-1:0]        dur,
    input  logic                       clr,
    input  logic                       pau,
    input  logic                       skip,
    output logic                       busy,
    output logic [N_STG-1:0]           ld_stg,
    output logic [N_STG-1:0]           cur_stg,
    output logic [TW-1:0]              u_cur,
    output logic [TW+$clog2(N_STG):0]  u_tot,
    output logic                       stg_done,
    output logic                       done
);

    localparam int                    c_TICK_W   = (TIM_CMAX > 1) ? $clog2(TIM_CMAX) : 1;
    localparam logic [c_TICK_W-1:0]   c_TICK_MAX = c_TICK_W'(TIM_CMAX - 1);
    localparam int                    c_UW       = TW + $clog2(N_STG) + 1;

    logic [N_STG-1:0]    r_st;
    logic [c_TICK_W-1:0] r_tick;
    logic [TW-1:0]       r_u_cur;
    logic                r_stg_done;
    logic                r_done;

    logic [N_STG-1:0]    w_cur;
    logic [N_STG-1:0]    w_nxt_st;
    logic                w_busy;
    logic                w_wrap;
    logic                w_end;
    logic [c_UW-1:0]     w_tot;

    // One-hot of the stage that runs first out of mask m.
    function automatic logic [N_STG-1:0] f_first(input logic [N_STG-1:0] m);
        logic [N_STG-1:0] r;
        r = '0;
        if (LSB_FIRST != 0) begin
            r = m & (~m + N_STG'(1));
        end else begin
            for (int i = 0; i < N_STG; i++) begin
                if (m[i]) begin
                    r    = '0;
                    r[i] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] f_dur(input logic [N_STG-1:0]    oh,
                                           input logic [N_STG*TW-1:0] d);
        logic [TW-1:0] r;
        r = '0;
        for (int i = 0; i < N_STG; i++) begin
            if (oh[i]) r = r | d[i*TW +: TW];
        end
        return r;
    endfunction

    always_comb begin
        w_cur    = f_first(r_st);
        w_nxt_st = r_st ^ w_cur;
        w_busy   = |r_st;
        w_wrap   = (r_tick == c_TICK_MAX);
        w_end    = w_busy && !pau &&
                   (skip || (r_u_cur == '0) || (w_wrap && (r_u_cur == TW'(1))));
    end

    // Remaining time follows live dur for every pending stage except the current one.
    always_comb begin
        w_tot = c_UW'(r_u_cur);
        for (int i = 0; i < N_STG; i++) begin
            if (r_st[i] && !w_cur[i]) w_tot = w_tot + c_UW'(dur[i*TW +: TW]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st       <= '0;
            r_tick     <= '0;
            r_u_cur    <= '0;
            r_stg_done <= 1'b0;
            r_done     <= 1'b0;
        end else if (clr) begin
            r_st       <= init;
            r_tick     <= '0;
            r_u_cur    <= f_dur(f_first(init), dur);
            r_stg_done <= 1'b0;
            r_done     <= 1'b0;
        end else if (w_end) begin
            r_st       <= w_nxt_st;
            r_tick     <= '0;
            r_u_cur    <= f_dur(f_first(w_nxt_st), dur);
            r_stg_done <= 1'b1;
            r_done     <= (w_nxt_st == '0);
        end else begin
            r_stg_done <= 1'b0;
            r_done     <= 1'b0;
            if (w_busy && !pau) begin
                if (w_wrap) begin
                    r_tick  <= '0;
                    r_u_cur <= r_u_cur - TW'(1);
                end else begin
                    r_tick  <= r_tick + c_TICK_W'(1);
                end
            end
        end
    end

    assign busy     = w_busy;
    assign ld_stg   = r_st;
    assign cur_stg  = w_cur;
    assign u_cur    = r_u_cur;
    assign u_tot    = w_tot;
    assign stg_done = r_stg_done;
    assign done     = r_done;

endmodule
`default_nettype wire
